mem_access_unit: RTL

//   Memory-stage controller between EX/MEM buffer and mem_wb_buffer. Decodes the mem op, drives a
//   req/ack data-memory port (variable latency), aligns/extends loads, steers store byte lanes.

---
 rtl/mem_access_unit_pkg.sv | 72 +++++++
 rtl/mem_access_unit_if.sv | 18 +
 rtl/mem_access_unit_load_align.sv | 31 +++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// =====================================================================
// mem_access_unit_pkg : mem_ctrl field layout, size codes, FSM states
//                       and byte-lane helpers for the memory stage.
// Rev 1.0
// =====================================================================
package mem_access_unit_pkg;

  localparam int MC_READ     = 0;
  localparam int MC_WRITE    = 1;
  localparam int MC_SIZE_LO  = 2;
  localparam int MC_SIZE_HI  = 3;
  localparam int MC_UNSIGNED = 4;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       write;
    logic [1:0] size;
    logic       uns;
  } mem_op_t;

  // read+write together is a write; the reserved size code 11 is a word
  function automatic mem_op_t decode_op(input logic [4:0] ctrl);
    mem_op_t op;
    op.valid = ctrl[MC_READ] | ctrl[MC_WRITE];
    op.write = ctrl[MC_WRITE];
    op.size  = (ctrl[MC_SIZE_HI:MC_SIZE_LO] == 2'b11) ? SIZE_W
                                                      : ctrl[MC_SIZE_HI:MC_SIZE_LO];
    op.uns   = ctrl[MC_UNSIGNED];
    return op;
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_H:  return ~lo[0];
      SIZE_W:  return (lo == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  // Loads carry only the access width; the lane is extracted from the full word.
  function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                              input logic [1:0] lo,
                                              input logic       write);
    case (size)
      SIZE_B:  return write ? (4'b0001 << lo) : 4'b0001;
      SIZE_H:  return (write && lo[1]) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate_store(input logic [1:0]  size,
                                                  input logic [31:0] sd);
    case (size)
      SIZE_B:  return {4{sd[7:0]}};
      SIZE_H:  return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// =====================================================================
// mem_access_unit_if : req/ack data-memory port (variable latency).
// Rev 1.0
// =====================================================================
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, be, wdata, input rdata, ack);
  modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
`default_nettype none
// =====================================================================
// mem_access_unit_load_align : picks the addressed byte/half out of the
//                              read word and sign/zero extends it.
// Rev 1.0
// =====================================================================
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SIZE_B:  data = {{24{~uns & byte_sel[7]}}, byte_sel};
      SIZE_H:  data = {{16{~uns & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// =====================================================================
// mem_access_unit : memory-stage controller; issues one data-memory
//                   access per op, stalls the pipe until it completes.
// Rev 1.0
// =====================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               mem_ctrl,
  input  logic [31:0]              addr,
  input  logic [31:0]              store_data,
  mem_access_unit_if.master        dmem,
  output logic [31:0]              mem_data,
  output logic                     stall,
  output logic                     misalign,
  output logic                     bus_fault
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       off_q, off_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;

  mem_op_t          op;
  logic             aligned;
  logic [31:0]      load_word;

  // Alignment uses the held op: inputs may change once the access is issued.
  mem_access_unit_load_align u_load_align (
    .rdata   (dmem.rdata),
    .addr_lo (off_q),
    .size    (size_q),
    .uns     (uns_q),
    .data    (load_word)
  );

  always_comb begin
    op        = decode_op(mem_ctrl);
    aligned   = is_aligned(op.size, addr[1:0]);
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    off_d     = off_q;
    size_d    = size_q;
    uns_d     = uns_q;
    stall     = 1'b0;
    misalign  = 1'b0;
    bus_fault = 1'b0;
    mem_data  = '0;

    case (state_q)
      ST_IDLE: begin
        if (op.valid) begin
          if (!aligned) begin
            misalign = 1'b1;
          end else begin
            stall   = 1'b1;
            req_d   = 1'b1;
            we_d    = op.write;
            addr_d  = {addr[31:2], 2'b00};
            be_d    = byte_enables(op.size, addr[1:0], op.write);
            wdata_d = op.write ? replicate_store(op.size, store_data) : '0;
            off_d   = addr[1:0];
            size_d  = op.size;
            uns_d   = op.uns;
            cnt_d   = '0;
            state_d = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem.ack) begin
          req_d   = 1'b0;
          rdata_d = we_q ? '0 : load_word;
          state_d = ST_DONE;
        end else if (cnt_q == LAST_WAIT) begin
          bus_fault = 1'b1;
          req_d     = 1'b0;
          rdata_d   = '0;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        mem_data = rdata_q;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // While reset is held the pipeline must not see a stall from a pending op.
    if (!rst) begin
      stall     = 1'b0;
      misalign  = 1'b0;
      bus_fault = 1'b0;
      mem_data  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      off_q   <= '0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
    end
  end

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.be    = be_q;
  assign dmem.wdata = wdata_q;

endmodule
`default_nettype wire
